ram_sp_clr: RTL and testbench

- Parametrised single-port synchronous RAM; successor to the fixed 4K x 16 RAM.
- Adds generic width/depth, per-lane write mask, registered read with a valid strobe, and a hardware clear engine that sweeps every word to a fill value.
- Serves as the general scratch/buffer memory for the lab datapaths.

---
 rtl/ram_pkg.sv | 25 ++
 rtl/ram_clr_ctrl.sv | 102 ++++++++++
 rtl/ram_sp_clr.sv | 88 ++++++++
 tb/tb_ram_sp_clr.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared definitions for the ram_sp_clr single-port RAM:
//                FSM state encoding, default widths, lane-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 12;

    // Clear-engine states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Width of one write-mask lane
    function automatic int lane_width(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_clr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_clr_ctrl
//  Description : Clear-sweep FSM, sweep counter, busy/err generation and the
//                write-port mux (user port in IDLE, clear port while sweeping).
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_clr_ctrl
    import ram_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                LANES      = 2,
    parameter logic [DATA_W-1:0] CLR_VAL    = '0,
    parameter int                CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              e,
    input  logic              w,
    input  logic              r,
    input  logic              clr,
    input  logic [LANES-1:0]  wmask,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [LANES-1:0]  mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              rd_en,
    output logic              busy,
    output logic              err
);

    localparam state_t c_RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [ADDR_W:0]   w_cnt_inc;
    logic              r_err;
    logic              w_access;

    // Carry into the extra top bit marks the write of the last word
    assign w_cnt_inc = r_cnt + {{ADDR_W{1'b0}}, 1'b1};
    assign w_access  = e & (w | r);

    // State and sweep-counter register; reset restarts any sweep from word 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; clr during a sweep is deliberately ignored
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (w_cnt_inc[ADDR_W]) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // One-cycle error pulse for any enabled access attempted mid-sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= busy & w_access;
        end
    end

    assign busy     = (r_state == ST_CLEAR);
    assign err      = r_err;
    assign rd_en    = e & r & ~busy;
    assign mem_we   = busy ? {LANES{1'b1}} : ((e & w) ? wmask : {LANES{1'b0}});
    assign mem_addr = busy ? r_cnt[ADDR_W-1:0] : addr;
    assign mem_din  = busy ? CLR_VAL : din;

endmodule
`default_nettype wire

// File: rtl/ram_sp_clr.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sp_clr
//  Description : Parametrised single-port synchronous RAM with per-lane write
//                mask, registered read with valid strobe and hardware clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_sp_clr
    import ram_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                LANES      = 2,
    parameter logic [DATA_W-1:0] CLR_VAL    = '0,
    parameter int                CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              e,
    input  logic              w,
    input  logic              r,
    input  logic [LANES-1:0]  wmask,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] DIn,
    input  logic              clr,
    output logic [DATA_W-1:0] DOut,
    output logic              DValid,
    output logic              busy,
    output logic              err
);

    localparam int c_LANE_W = lane_width(DATA_W, LANES);
    localparam int c_DEPTH  = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [LANES-1:0]  w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_din;
    logic              w_rd_en;

    ram_clr_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LANES      (LANES),
        .CLR_VAL    (CLR_VAL),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .e        (e),
        .w        (w),
        .r        (r),
        .clr      (clr),
        .wmask    (wmask),
        .addr     (addr),
        .din      (DIn),
        .mem_we   (w_mem_we),
        .mem_addr (w_mem_addr),
        .mem_din  (w_mem_din),
        .rd_en    (w_rd_en),
        .busy     (busy),
        .err      (err)
    );

    // Lane-masked write into the array (storage itself is never reset)
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (w_mem_we[k]) begin
                r_mem[w_mem_addr][k*c_LANE_W +: c_LANE_W] <= w_mem_din[k*c_LANE_W +: c_LANE_W];
            end
        end
    end

    // Registered read; non-blocking update gives read-first on a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DOut   <= '0;
            DValid <= 1'b0;
        end else begin
            DValid <= w_rd_en;
            if (w_rd_en) begin
                DOut <= r_mem[addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_clr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_sp_clr
//  Description : Self-checking bench for ram_sp_clr (16 x 4096, 2 lanes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sp_clr;

    localparam int c_BOUND = 10000;

    logic        clk;
    logic        rst_n;
    logic        e;
    logic        w;
    logic        r;
    logic [1:0]  wmask;
    logic [11:0] addr;
    logic [15:0] DIn;
    logic        clr;
    logic [15:0] DOut;
    logic        DValid;
    logic        busy;
    logic        err;

    int checks;
    int failures;
    logic [15:0] exp_q[$];

    typedef struct packed {
        logic        w;
        logic        r;
        logic [1:0]  m;
        logic [11:0] a;
        logic [15:0] d;
        logic [15:0] x;
    } vec_t;

    vec_t tbl[10];

    ram_sp_clr #(
        .DATA_W     (16),
        .ADDR_W     (12),
        .LANES      (2),
        .CLR_VAL    (16'h0000),
        .CLR_ON_RST (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .e      (e),
        .w      (w),
        .r      (r),
        .wmask  (wmask),
        .addr   (addr),
        .DIn    (DIn),
        .clr    (clr),
        .DOut   (DOut),
        .DValid (DValid),
        .busy   (busy),
        .err    (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drive(input logic e_i, input logic w_i, input logic r_i,
                         input logic [1:0] m_i, input logic [11:0] a_i,
                         input logic [15:0] d_i, input logic c_i);
        @(negedge clk);
        e     = e_i;
        w     = w_i;
        r     = r_i;
        wmask = m_i;
        addr  = a_i;
        DIn   = d_i;
        clr   = c_i;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle-state access: reads push their expected data, popped after the edge
    task automatic access(input string nm, input logic w_i, input logic r_i,
                          input logic [1:0] m_i, input logic [11:0] a_i,
                          input logic [15:0] d_i, input logic [15:0] x_i);
        logic [15:0] got;
        drive(1'b1, w_i, r_i, m_i, a_i, d_i, 1'b0);
        if (r_i) exp_q.push_back(x_i);
        tick();
        if (r_i) begin
            check({nm, "_dvalid"}, DValid, 1);
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                check({nm, "_dout"}, DOut, got);
            end
        end else begin
            check({nm, "_novalid"}, DValid, 0);
        end
        check({nm, "_err"}, err, 0);
    endtask

    // Count edges until busy drops, bounded
    task automatic count_busy(input int start, output int n);
        n = start;
        while (busy && n < c_BOUND) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;

        tbl[0] = '{1'b1, 1'b0, 2'b11, 12'd5, 16'hABCD, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 2'b01, 12'd5, 16'h1234, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 2'b00, 12'd5, 16'h0000, 16'hAB34};
        tbl[3] = '{1'b1, 1'b0, 2'b11, 12'd7, 16'h0011, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 2'b11, 12'd7, 16'h0022, 16'h0011};
        tbl[5] = '{1'b0, 1'b1, 2'b00, 12'd7, 16'h0000, 16'h0022};
        tbl[6] = '{1'b1, 1'b0, 2'b00, 12'd7, 16'hFFFF, 16'h0000};
        tbl[7] = '{1'b0, 1'b1, 2'b00, 12'd7, 16'h0000, 16'h0022};
        tbl[8] = '{1'b1, 1'b0, 2'b10, 12'd9, 16'h5A5A, 16'h0000};
        tbl[9] = '{1'b0, 1'b1, 2'b00, 12'd9, 16'h0000, 16'h5A00};

        rst_n = 1'b0;
        e = 1'b0; w = 1'b0; r = 1'b0; wmask = 2'b00;
        addr = '0; DIn = '0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout",   DOut,   0);
        check("rst_dvalid", DValid, 0);
        check("rst_err",    err,    0);
        check("rst_busy",   busy,   1);

        // Power-on sweep length
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        count_busy(0, n);
        check("por_sweep_len", n, 4096);

        access("clr_rd0",    1'b0, 1'b1, 2'b00, 12'd0,    16'h0, 16'h0000);
        access("clr_rd2048", 1'b0, 1'b1, 2'b00, 12'd2048, 16'h0, 16'h0000);
        access("clr_rd4095", 1'b0, 1'b1, 2'b00, 12'd4095, 16'h0, 16'h0000);

        // Stride pattern
        for (int i = 0; i < 32; i++)
            access("stride_wr", 1'b1, 1'b0, 2'b11, 12'(32*i), 16'(i), 16'h0);
        for (int i = 0; i < 32; i++)
            access($sformatf("stride_rd%0d", i), 1'b0, 1'b1, 2'b00, 12'(32*i), 16'd100, 16'(i));

        // Mask, collision and zero-mask vectors
        for (int i = 0; i < 10; i++)
            access($sformatf("vec%0d", i), tbl[i].w, tbl[i].r, tbl[i].m, tbl[i].a, tbl[i].d, tbl[i].x);

        // Access during busy; second clr mid-sweep must not restart it
        drive(1'b0, 1'b0, 1'b0, 2'b00, 12'd0, 16'h0, 1'b1);
        tick();
        check("clr_busy", busy, 1);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 12'd3, 16'h0, 1'b0);
        tick();
        check("busy_rd_err",    err,    1);
        check("busy_rd_dvalid", DValid, 0);
        check("busy_rd_dout",   DOut,   16'h5A00);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 12'd0, 16'h0, 1'b0);
        tick();
        check("err_one_cycle", err, 0);
        drive(1'b0, 1'b1, 1'b1, 2'b11, 12'd3, 16'hFFFF, 1'b0);
        tick();
        check("busy_e0_err",    err,    0);
        check("busy_e0_dvalid", DValid, 0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 12'd0, 16'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 12'd0, 16'h0, 1'b0);
        count_busy(4, n);
        check("reclr_sweep_len", n, 4096);
        access("after_clr_rd9", 1'b0, 1'b1, 2'b00, 12'd9, 16'h0, 16'h0000);

        // Reset mid-sweep
        access("pre_rst_wr", 1'b1, 1'b0, 2'b11, 12'd5, 16'hBEEF, 16'h0);
        access("pre_rst_rd", 1'b0, 1'b1, 2'b00, 12'd5, 16'h0,    16'hBEEF);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 12'd0, 16'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 12'd0, 16'h0, 1'b0);
        repeat (999) tick();
        check("mid_sweep_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_dout",   DOut,   0);
        check("midrst_dvalid", DValid, 0);
        check("midrst_busy",   busy,   1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        count_busy(0, n);
        check("rst_sweep_len", n, 4096);
        access("post_rst_rd5",    1'b0, 1'b1, 2'b00, 12'd5,    16'h0, 16'h0000);
        access("post_rst_rd4095", 1'b0, 1'b1, 2'b00, 12'd4095, 16'h0, 16'h0000);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
